// File: rtl/tcm_loader.sv
// tcm_loader: assembles an inbound little-endian byte stream into 32-bit
// words and writes them to consecutive TCM addresses, wrapping at N_ENTRIES.
// Optional feature macro: TCM_LOADER_CHECKSUM_EN -- after the last write the
// loaded region is read back and summed into checksum_o.
// All outputs are registered; they are decoded from the next state so they
// line up with the state they describe.
module tcm_loader #(
    parameter int N_ENTRIES = 1024,
    localparam int AW = $clog2(N_ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   nwords_i,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_data_o,
    input  logic [31:0]   mem_data_i,
    input  logic          mem_ready_i,
    output logic          busy_o,
    output logic          done_o
`ifdef TCM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]   checksum_o
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Word address increment that wraps at N_ENTRIES (need not be a power of 2).
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        logic [AW-1:0] n;
        if (a == AW'(N_ENTRIES - 1)) begin
            n = AW'(0);
        end else begin
            n = a + AW'(1);
        end
        return n;
    endfunction

    logic [2:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_nwords;
    logic [1:0]    r_bidx;
    logic [31:0]   r_word;
    logic          r_byte_ready;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [3:0]    r_mem_be;
    logic          r_busy;
    logic          r_done;

    logic [2:0]    w_state_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [AW:0]   w_cnt_nxt;
    logic [AW:0]   w_nwords_nxt;
    logic [1:0]    w_bidx_nxt;
    logic [31:0]   w_word_nxt;
    logic [AW:0]   w_cnt_inc;
    logic          w_xfer;

`ifdef TCM_LOADER_CHECKSUM_EN
    logic [AW-1:0] r_base;
    logic [31:0]   r_checksum;
    logic [AW-1:0] w_base_nxt;
    logic [31:0]   w_checksum_nxt;
`else
    // Read-back inputs have no consumer when the checksum feature is absent.
    logic w_unused_rd;
    assign w_unused_rd = ^{mem_data_i, mem_ready_i};
`endif

    assign w_xfer    = byte_valid_i & r_byte_ready;
    assign w_cnt_inc = r_cnt + (AW+1)'(1);

    // Next-state and datapath computation for the load / read-back sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        w_nwords_nxt = r_nwords;
        w_bidx_nxt   = r_bidx;
        w_word_nxt   = r_word;
`ifdef TCM_LOADER_CHECKSUM_EN
        w_base_nxt     = r_base;
        w_checksum_nxt = r_checksum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
`ifdef TCM_LOADER_CHECKSUM_EN
                    w_checksum_nxt = 32'h0000_0000;
                    w_base_nxt     = base_i;
`endif
                    if (nwords_i != (AW+1)'(0)) begin
                        w_addr_nxt   = base_i;
                        w_nwords_nxt = nwords_i;
                        w_cnt_nxt    = (AW+1)'(0);
                        w_bidx_nxt   = 2'd0;
                        w_word_nxt   = 32'h0000_0000;
                        w_state_nxt  = ST_COLLECT;
                    end else begin
                        // Empty load: finish without touching memory or the stream.
                        w_state_nxt  = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (w_xfer) begin
                    w_word_nxt[{r_bidx, 3'b000} +: 8] = byte_i;
                    w_bidx_nxt = r_bidx + 2'd1;
                    if (r_bidx == 2'd3) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_COLLECT;
                    end
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                w_addr_nxt = addr_inc(r_addr);
                w_cnt_nxt  = w_cnt_inc;
                if (w_cnt_inc < r_nwords) begin
                    w_state_nxt = ST_COLLECT;
                end else begin
`ifdef TCM_LOADER_CHECKSUM_EN
                    // Rewind to the start of the region for the read-back pass.
                    w_addr_nxt  = r_base;
                    w_cnt_nxt   = (AW+1)'(0);
                    w_state_nxt = ST_RD_REQ;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
`ifdef TCM_LOADER_CHECKSUM_EN
            ST_RD_REQ: begin
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_ready_i) begin
                    w_checksum_nxt = r_checksum + mem_data_i;
                    w_addr_nxt     = addr_inc(r_addr);
                    w_cnt_nxt      = w_cnt_inc;
                    if (w_cnt_inc < r_nwords) begin
                        w_state_nxt = ST_RD_REQ;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_RD_WAIT;
                end
            end
`endif
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and next-state-decoded output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_addr       <= AW'(0);
            r_cnt        <= (AW+1)'(0);
            r_nwords     <= (AW+1)'(0);
            r_bidx       <= 2'd0;
            r_word       <= 32'h0000_0000;
            r_byte_ready <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'h0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_nwords     <= w_nwords_nxt;
            r_bidx       <= w_bidx_nxt;
            r_word       <= w_word_nxt;
            r_byte_ready <= (w_state_nxt == ST_COLLECT);
            r_mem_en     <= (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_RD_REQ);
            r_mem_we     <= (w_state_nxt == ST_WRITE);
            r_mem_be     <= (w_state_nxt == ST_WRITE) ? 4'hF : 4'h0;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

`ifdef TCM_LOADER_CHECKSUM_EN
    // Read-back base and running checksum; checksum holds from DONE to next start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base     <= AW'(0);
            r_checksum <= 32'h0000_0000;
        end else begin
            r_base     <= w_base_nxt;
            r_checksum <= w_checksum_nxt;
        end
    end

    assign checksum_o = r_checksum;
`endif

    assign byte_ready_o = r_byte_ready;
    assign mem_en_o     = r_mem_en;
    assign mem_we_o     = r_mem_we;
    assign mem_be_o     = r_mem_be;
    assign mem_addr_o   = r_addr;
    assign mem_data_o   = r_word;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
